// File: rtl/btn_debounce_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pkg
// Shared constants and helpers for the front-panel button debouncer.
//   DEF_N_CH          default channel count
//   DEF_STABLE_CNT    default number of consecutive disagreeing samples to flip
//   DEF_REPEAT_DELAY  default hold samples before the first auto-repeat pulse
//   DEF_REPEAT_PERIOD default samples between subsequent auto-repeat pulses
//   cnt_w(max)        width of a counter that must hold values 0..max
// -----------------------------------------------------------------------------
package btn_debounce_pkg;

    localparam int unsigned DEF_N_CH          = 6;
    localparam int unsigned DEF_STABLE_CNT    = 4;
    localparam int unsigned DEF_REPEAT_DELAY  = 100;
    localparam int unsigned DEF_REPEAT_PERIOD = 20;

    // Never returns 0 so a degenerate parameter still yields a legal vector.
    function automatic int unsigned cnt_w(input int unsigned max);
        if (max < 32'd1) begin
            return 32'd1;
        end
        return unsigned'($clog2(max + 32'd1));
    endfunction

endpackage : btn_debounce_pkg

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One debounce channel: two-flop synchroniser, stability counter, debounced
// level, registered press/release pulses and (optionally) hold-to-repeat.
// Optional feature macro: BTN_DEBOUNCE_REPEAT_EN (auto-repeat hold counter).
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   sample_en_i  one-cycle sampling strobe
//   btn_i        raw asynchronous input (inverted by IN_INV before sync)
//   level_o      debounced level, 1 = pressed
//   rise_o       one-cycle pulse coinciding with level_o going 0->1
//   fall_o       one-cycle pulse coinciding with level_o going 1->0
//   rep_o        one-cycle auto-repeat pulse (0 when repeat is compiled out)
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT    = DEF_STABLE_CNT,
    parameter logic        IN_INV        = 1'b0,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sample_en_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic rep_o
);

    localparam int unsigned CW = cnt_w(STABLE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    logic          s0_q, s1_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          flip;

    // Level flips on the STABLE_CNT-th consecutive disagreeing sample; any
    // agreeing sample in between restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        flip    = 1'b0;
        if (sample_en_i) begin
            if (s1_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    flip    = 1'b1;
                    level_d = ~level_q;
                    cnt_d   = '0;
                    rise_d  = ~level_q;
                    fall_d  = level_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s0_q    <= btn_i ^ IN_INV;
            s1_q    <= s0_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int unsigned HW = cnt_w(REPEAT_DELAY);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 32'd1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(32'd1);
    // The count that would equal REPEAT_DELAY is never stored: the pulse fires
    // on the sample that would reach it and the counter loads the reload value
    // directly. A period not shorter than the delay reloads to 0.
    localparam logic [HW-1:0] HOLD_RELOAD =
        (REPEAT_PERIOD >= REPEAT_DELAY) ? '0 : HW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;

    // Released level or a falling sample clears the hold count, so no repeat
    // can coincide with a fall (and none with a rise, since level was 0).
    always_comb begin
        hold_d = hold_q;
        rep_d  = 1'b0;
        if (!level_q) begin
            hold_d = '0;
        end else if (sample_en_i) begin
            if (flip) begin
                hold_d = '0;
            end else if (hold_q == HOLD_LAST) begin
                rep_d  = 1'b1;
                hold_d = HOLD_RELOAD;
            end else begin
                hold_d = hold_q + HOLD_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    assign rep_o = rep_q;
`else
    assign rep_o = 1'b0;
`endif

endmodule : btn_debounce_ch

// File: rtl/btn_debounce_pro.sv
// -----------------------------------------------------------------------------
// btn_debounce_pro
// Multi-channel debouncer for front-panel buttons and switches, sampled on a
// one-cycle sample_en strobe. Each channel is an independent btn_debounce_ch.
// Optional feature macro: BTN_DEBOUNCE_REPEAT_EN (hold-to-repeat on btn_rep).
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sample_en  one-cycle sampling strobe
//   btn_in     raw asynchronous inputs, N_CH bits (IN_INV bit set = active-low)
//   btn_level  debounced levels, 1 = pressed
//   btn_rise   one-cycle pulse per channel on a 0->1 level change
//   btn_fall   one-cycle pulse per channel on a 1->0 level change
//   btn_rep    one-cycle auto-repeat pulses (constant 0 without the macro)
// -----------------------------------------------------------------------------
module btn_debounce_pro
    import btn_debounce_pkg::*;
#(
    parameter int unsigned     N_CH          = DEF_N_CH,
    parameter int unsigned     STABLE_CNT    = DEF_STABLE_CNT,
    parameter logic [N_CH-1:0] IN_INV        = '0,
    parameter int unsigned     REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned     REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sample_en,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_rep
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CNT    (STABLE_CNT),
            .IN_INV        (IN_INV[i]),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .sample_en_i (sample_en),
            .btn_i       (btn_in[i]),
            .level_o     (btn_level[i]),
            .rise_o      (btn_rise[i]),
            .fall_o      (btn_fall[i]),
            .rep_o       (btn_rep[i])
        );
    end

endmodule : btn_debounce_pro

// File: tb/tb_btn_debounce_pro.sv
module tb_btn_debounce_pro;

    localparam int N = 6;
    localparam int K = 4;
    localparam int D = 8;
    localparam int P = 3;
    localparam logic [N-1:0] INV = 6'b100001;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int EXP_REP = 5;
    localparam bit REP_ON  = 1'b1;
`else
    localparam int EXP_REP = 0;
    localparam bit REP_ON  = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         sample_en = 1'b0;
    logic [N-1:0] btn_in = INV;
    logic [N-1:0] btn_level, btn_rise, btn_fall, btn_rep;

    always #5 clk = ~clk;

    btn_debounce_pro #(
        .N_CH          (N),
        .STABLE_CNT    (K),
        .IN_INV        (INV),
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_rep   (btn_rep)
    );

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    int phase  = 0;
    bit last_se;

    // Reference model: level flips once the last K samples (taken since the
    // previous flip) all disagree with it; repeat fires at hold sample n when
    // n >= D and (n - D) is a multiple of P.
    logic [N-1:0] m_level, m_rise, m_fall, m_rep, m_s0, m_s1;
    logic [K-1:0] m_hist [N];
    int           m_nsamp [N];
    int           m_hold [N];

    int n_rise [N];
    int n_fall [N];
    int n_rep [N];
    int rise_cyc [N];
    int fall_cyc [N];

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = '0; m_rise = '0; m_fall = '0; m_rep = '0;
        m_s0 = '0; m_s1 = '0;
        for (int c = 0; c < N; c++) begin
            m_hist[c] = '0; m_nsamp[c] = 0; m_hold[c] = 0;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] raw, input logic se);
        logic [K-1:0] against;
        logic         old;
        logic         flip;
        m_rise = '0; m_fall = '0; m_rep = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (se) begin
            for (int c = 0; c < N; c++) begin
                old     = m_level[c];
                against = old ? {K{1'b0}} : {K{1'b1}};
                m_hist[c] = {m_hist[c][K-2:0], m_s1[c]};
                if (m_nsamp[c] < K) m_nsamp[c]++;
                flip = (m_nsamp[c] >= K) && (m_hist[c] == against);
                if (flip) begin
                    m_level[c] = ~old;
                    m_nsamp[c] = 0;
                    if (old) m_fall[c] = 1'b1;
                    else     m_rise[c] = 1'b1;
                end
                if (old && !flip) begin
                    m_hold[c]++;
                    if (REP_ON && m_hold[c] >= D && ((m_hold[c] - D) % P) == 0)
                        m_rep[c] = 1'b1;
                end else begin
                    m_hold[c] = 0;
                end
            end
        end
        m_s1 = m_s0;
        m_s0 = raw ^ INV;
    endtask

    task automatic tick(input logic [N-1:0] raw, input logic se);
        btn_in    = raw;
        sample_en = se;
        last_se   = se;
        @(posedge clk);
        model_edge(raw, se);
        #1;
        cyc_no++;
        chk("level", btn_level, m_level);
        chk("rise",  btn_rise,  m_rise);
        chk("fall",  btn_fall,  m_fall);
        chk("rep",   btn_rep,   m_rep);
        for (int c = 0; c < N; c++) begin
            if (btn_rise[c]) begin n_rise[c]++; rise_cyc[c] = cyc_no; end
            if (btn_fall[c]) begin n_fall[c]++; fall_cyc[c] = cyc_no; end
            if (btn_rep[c])  n_rep[c]++;
        end
    endtask

    // sample_en once every 10 clk
    task automatic step1(input logic [N-1:0] raw);
        tick(raw, (phase % 10) == 0);
        phase++;
    endtask

    task automatic run(input logic [N-1:0] raw, input int ncyc);
        for (int i = 0; i < ncyc; i++) step1(raw);
    endtask

    task automatic clr_obs();
        for (int c = 0; c < N; c++) begin
            n_rise[c] = 0; n_fall[c] = 0; n_rep[c] = 0;
            rise_cyc[c] = -1; fall_cyc[c] = -1;
        end
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int c = 0; c < N; c++) s += n_rise[c] + n_fall[c] + n_rep[c];
        return s;
    endfunction

    function automatic logic [N-1:0] pressed(input logic [N-1:0] mask);
        return INV ^ mask;
    endfunction

    initial begin
        int t0;
        int smp;
        int rise_smp;
        logic [N-1:0] raw;

        model_reset();
        clr_obs();
        #2 rst_n = 1'b0;
        #1;
        chk("rst0_level", btn_level, '0);
        chk("rst0_rise",  btn_rise,  '0);
        chk("rst0_fall",  btn_fall,  '0);
        chk("rst0_rep",   btn_rep,   '0);
        run(INV, 5);
        rst_n = 1'b1;
        run(INV, 50);
        chk_int("idle_pulses", total_pulses(), 0);

        // Random bounce on all channels, mixed strobe patterns
        for (int seg = 0; seg < 24; seg++) begin
            int len;
            raw = INV ^ N'($urandom);
            len = $urandom_range(1, 60);
            for (int i = 0; i < len; i++) begin
                if (seg % 4 == 0) tick(raw, 1'b1);
                else              tick(raw, $urandom_range(0, 2) == 0);
            end
        end
        run(INV, 100);
        chk("settled_level", btn_level, '0);

        // Reset mid-run while a level is high
        run(pressed(6'b001000), 80);
        chk_int("pre_rst_level3", int'(btn_level[3]), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_level", btn_level, '0);
        chk("rst_async_rise",  btn_rise,  '0);
        chk("rst_async_fall",  btn_fall,  '0);
        chk("rst_async_rep",   btn_rep,   '0);
        run(INV, 3);
        rst_n = 1'b1;
        clr_obs();
        run(INV, 50);
        chk_int("post_rst_pulses", total_pulses(), 0);

        // Clean press on channel 2
        clr_obs();
        t0 = cyc_no;
        run(pressed(6'b000100), 80);
        chk_int("press_rise2", n_rise[2], 1);
        chk_int("press_level2", int'(btn_level[2]), 1);
        chk_int("press_others", total_pulses() - n_rise[2], 0);
        chk_int("press_lat", int'((rise_cyc[2] - t0) >= 33 && (rise_cyc[2] - t0) <= 42), 1);
        run(INV, 80);
        chk_int("release_fall2", n_fall[2], 1);

        // Glitch of 3 samples on channel 0 (active-low input)
        clr_obs();
        run(pressed(6'b000001), 30);
        run(INV, 60);
        chk_int("glitch3_rise0", n_rise[0], 0);
        chk_int("glitch3_fall0", n_fall[0], 0);
        chk_int("glitch3_level0", int'(btn_level[0]), 0);

        // 5 samples: one rise, then one fall 4 samples after release
        clr_obs();
        run(pressed(6'b000001), 50);
        t0 = cyc_no;
        run(INV, 80);
        chk_int("pulse5_rise0", n_rise[0], 1);
        chk_int("pulse5_fall0", n_fall[0], 1);
        chk_int("pulse5_fall_lat", int'((fall_cyc[0] - t0) >= 33 && (fall_cyc[0] - t0) <= 42), 1);

        // Simultaneous press on the two inverted channels
        clr_obs();
        run(pressed(6'b100001), 60);
        chk_int("simul_rise0", n_rise[0], 1);
        chk_int("simul_rise5", n_rise[5], 1);
        chk_int("simul_same_cyc", rise_cyc[0], rise_cyc[5]);
        run(INV, 80);

        // Hold-to-repeat on channel 1
        clr_obs();
        raw = pressed(6'b000010);
        for (int i = 0; i < 100 && n_rise[1] == 0; i++) step1(raw);
        chk_int("rep_rise_seen", n_rise[1], 1);
        run(raw, 200);
        chk_int("rep_count20", n_rep[1], EXP_REP);
        for (int i = 0; i < 100 && n_fall[1] == 0; i++) step1(INV);
        chk_int("rep_fall_seen", n_fall[1], 1);
        n_rep[1] = 0;
        run(INV, 100);
        chk_int("rep_after_fall", n_rep[1], 0);

        // Reset with a partial count on channel 4
        clr_obs();
        raw = pressed(6'b010000);
        for (int i = 0; i < 100 && !(m_hist[4][1:0] == 2'b11 && m_level[4] == 1'b0); i++)
            step1(raw);
        chk_int("midcnt_reached", int'(m_hist[4][1:0] == 2'b11 && m_level[4] == 1'b0), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midcnt_rst_level", btn_level, '0);
        run(raw, 3);
        rst_n = 1'b1;
        clr_obs();
        smp = 0;
        rise_smp = -1;
        for (int i = 0; i < 100 && n_rise[4] == 0; i++) begin
            step1(raw);
            if (last_se) smp++;
            if (n_rise[4] != 0) rise_smp = smp;
        end
        chk_int("midcnt_rise4", n_rise[4], 1);
        chk_int("midcnt_full_count", int'(rise_smp >= 4 && rise_smp <= 5), 1);
        run(INV, 80);
        chk("final_level", btn_level, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_btn_debounce_pro
